// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART transmit arbiter.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above i_ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // First pass covers ptr..NREQ-1, second pass the wrapped range below ptr.
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDXW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!o_any && i_req[i]) begin
        o_any      = 1'b1;
        o_grant[i] = 1'b1;
        o_idx      = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NREQ byte producers, with bounded bursts.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*8-1:0]        i_req_data,
  input  logic [NREQ-1:0]          i_req_last,
  output logic [NREQ-1:0]          o_req_ready,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_busy,
  input  logic                     i_tx_done,
  output logic [$clog2(NREQ)-1:0]  o_grant_id,
  output logic                     o_active,
  output logic                     o_timeout_err
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned TOW  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  arb_state_t      r_state;
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_owner;
  logic [7:0]      r_burst_cnt;
  logic [TOW-1:0]  r_to_cnt;
  logic            r_last;
  uart_byte_t      r_tx_data;
  logic            r_tx_start;
  logic            r_active;
  logic            r_timeout_err;

  logic [NREQ-1:0] w_pick_grant;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_any;
  logic [NREQ-1:0] w_owner_onehot;
  logic            w_done_evt;
  logic            w_chain;
  logic            w_timeout;
  logic [IDXW-1:0] w_next_ptr;
  logic [IDXW-1:0] w_acc_idx;
  uart_byte_t      w_acc_data;
  logic            w_acc_last;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
  // tx_done only counts once a byte has actually been started.
  assign w_done_evt = ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) && i_tx_done;
  assign w_chain    = i_req_valid[r_owner] && !r_last && (r_burst_cnt < 8'(MAX_BURST));
  assign w_timeout  = (r_state == WAIT_BUSY) && !i_tx_busy && !i_tx_done &&
                      (r_to_cnt == TOW'(START_TIMEOUT - 1));
  assign w_next_ptr = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);
  assign w_acc_idx  = (r_state == IDLE) ? w_pick_idx : r_owner;

  always_comb begin
    w_acc_data = '0;
    w_acc_last = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDXW'(k) == w_acc_idx) begin
        w_acc_data = i_req_data[8*k +: 8];
        w_acc_last = i_req_last[k];
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (r_state == IDLE) begin
      o_req_ready = w_pick_grant;
    end else if (w_done_evt && w_chain) begin
      o_req_ready = w_owner_onehot;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_burst_cnt   <= '0;
      r_to_cnt      <= '0;
      r_last        <= 1'b0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      if (w_done_evt) begin
        if (w_chain) begin
          r_tx_data   <= w_acc_data;
          r_last      <= w_acc_last;
          r_burst_cnt <= r_burst_cnt + 8'd1;
          r_tx_start  <= 1'b1;
          r_state     <= LOAD;
        end else begin
          r_active <= 1'b0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= IDLE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_any) begin
              r_tx_data   <= w_acc_data;
              r_last      <= w_acc_last;
              r_owner     <= w_pick_idx;
              r_active    <= 1'b1;
              r_burst_cnt <= 8'd1;
              r_tx_start  <= 1'b1;
              r_state     <= LOAD;
            end
          end
          LOAD: begin
            r_to_cnt <= '0;
            r_state  <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (i_tx_busy) begin
              r_state <= WAIT_DONE;
            end else if (w_timeout) begin
              // The stalled owner still advances the pointer so others get a turn.
              r_timeout_err <= 1'b1;
              r_active      <= 1'b0;
              r_rr_ptr      <= w_next_ptr;
              r_state       <= IDLE;
            end else begin
              r_to_cnt <= r_to_cnt + TOW'(1);
            end
          end
          WAIT_DONE: r_state <= WAIT_DONE;
          default:   r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_grant_id    = r_owner;
  assign o_active      = r_active;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx responder.
module tb_uart_tx_arbiter;

  localparam int NREQ          = 4;
  localparam int MAX_BURST     = 16;
  localparam int START_TIMEOUT = 4;
  localparam int BUSY_LEN      = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ          (NREQ),
    .MAX_BURST     (MAX_BURST),
    .START_TIMEOUT (START_TIMEOUT)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .i_req_last    (req_last),
    .o_req_ready   (req_ready),
    .o_tx_data     (tx_data),
    .o_tx_start    (tx_start),
    .i_tx_busy     (tx_busy),
    .i_tx_done     (tx_done),
    .o_grant_id    (grant_id),
    .o_active      (active),
    .o_timeout_err (timeout_err)
  );

  logic [8:0] prod_q [4][$];  // {last, data} per requester
  logic [9:0] sb_q [$];       // expected {grant_id, tx_data} per tx_start
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] acc;
  logic       start_seen;
  int         busy_cnt;
  int         mode;           // 0 normal, 1 done without busy, 2 never responds
  logic       inject_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic enq(input int id, input logic last, input logic [7:0] d);
    prod_q[id].push_back({last, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    logic [1:0] idv;
    idv = 2'(id);
    sb_q.push_back({idv, d});
  endtask

  task automatic drive_producers();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      if (prod_q[i].size() > 0) begin
        e = prod_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: update producers and uart model after the edge, then sample at negedge.
  task automatic step();
    logic [9:0] e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
    tx_done = 1'b0;
    if (inject_done) begin
      tx_done     = 1'b1;
      inject_done = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
    end else if (start_seen) begin
      if (mode == 0) begin
        tx_busy  = 1'b1;
        busy_cnt = BUSY_LEN;
      end else if (mode == 1) begin
        tx_done = 1'b1;
      end
    end
    drive_producers();
    @(negedge clk);
    acc        = req_valid & req_ready;
    start_seen = tx_start;
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    chk("ready_needs_valid", 32'(req_ready & ~req_valid), 0);
    if (tx_start) begin
      chk("start_while_uart_idle", 32'(busy_cnt == 0 && !tx_busy), 1);
      chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
        chk("active_at_start", 32'(active), 1);
      end
    end
  endtask

  function automatic bit quiet();
    bit q;
    q = (sb_q.size() == 0) && !active && (busy_cnt == 0) && !tx_busy;
    for (int i = 0; i < 4; i++) if (prod_q[i].size() != 0) q = 1'b0;
    return q;
  endfunction

  task automatic run_until_quiet(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (n < budget && !quiet());
    chk({tag, "_drained"}, 32'(quiet()), 1);
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (n < budget && !start_seen);
    chk(tag, 32'(start_seen), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_start"}, 32'(tx_start), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_timeout"}, 32'(timeout_err), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    tx_busy = 1'b0; tx_done = 1'b0; acc = '0; start_seen = 1'b0;
    busy_cnt = 0; mode = 0; inject_done = 1'b0;
    repeat (2) step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Single requester: same-cycle ready, start pulse next cycle.
    enq(0, 1'b1, 8'hA5); expect_byte(0, 8'hA5);
    step();
    chk("t1_ready", 32'(req_ready), 32'b0001);
    step();
    chk("t1_start", 32'(tx_start), 1);
    run_until_quiet(40, "t1");

    // Pointer moved to 1: requester 1 wins over 0.
    enq(0, 1'b1, 8'hB0); enq(1, 1'b1, 8'hB1);
    expect_byte(1, 8'hB1); expect_byte(0, 8'hB0);
    run_until_quiet(60, "t1b");

    rst = 1'b1; busy_cnt = 0; tx_busy = 1'b0;
    step();
    rst = 1'b0;
    step();

    // All four valid from pointer 0, single-byte messages.
    enq(0, 1'b1, 8'h10); enq(0, 1'b1, 8'h14);
    enq(1, 1'b1, 8'h11); enq(2, 1'b1, 8'h12); enq(3, 1'b1, 8'h13);
    expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
    expect_byte(3, 8'h13); expect_byte(0, 8'h14);
    run_until_quiet(120, "t2");

    // Three-byte message from requester 2 is not interleaved (pointer now 1).
    enq(2, 1'b0, 8'h11); enq(2, 1'b0, 8'h22); enq(2, 1'b1, 8'h33);
    enq(0, 1'b1, 8'h44);
    expect_byte(2, 8'h11); expect_byte(2, 8'h22); expect_byte(2, 8'h33);
    expect_byte(0, 8'h44);
    run_until_quiet(120, "t3");

    // Burst cap: 16 bytes, then requester 3, then requester 1 resumes.
    for (int i = 0; i < 20; i++) enq(1, 1'b0, 8'(8'h80 + i));
    enq(3, 1'b1, 8'hC0);
    for (int i = 0; i < 16; i++) expect_byte(1, 8'(8'h80 + i));
    expect_byte(3, 8'hC0);
    for (int i = 16; i < 20; i++) expect_byte(1, 8'(8'h80 + i));
    run_until_quiet(400, "t4");

    // Transmitter never goes busy: timeout, release, next requester.
    mode = 2;
    enq(2, 1'b1, 8'h5A); enq(3, 1'b1, 8'h6B);
    expect_byte(2, 8'h5A); expect_byte(3, 8'h6B);
    wait_start(20, "t5_start");
    repeat (4) step();
    chk("t5_no_early_timeout", 32'(timeout_err), 0);
    chk("t5_active_waiting", 32'(active), 1);
    step();
    chk("t5_timeout", 32'(timeout_err), 1);
    chk("t5_released", 32'(active), 0);
    chk("t5_next_ready", 32'(req_ready), 32'b1000);
    mode = 0;
    step();
    chk("t5_timeout_pulse", 32'(timeout_err), 0);
    run_until_quiet(60, "t5");

    // Reset while waiting for tx_done.
    enq(1, 1'b1, 8'h77); expect_byte(1, 8'h77);
    wait_start(20, "t6_start");
    repeat (2) step();
    chk("t6_active_before_rst", 32'(active), 1);
    rst = 1'b1; busy_cnt = 0; tx_busy = 1'b0;
    step();
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    enq(2, 1'b1, 8'h99); expect_byte(2, 8'h99);
    step();
    chk("t6_ready", 32'(req_ready), 32'b0100);
    run_until_quiet(60, "t6");

    // Fast transmitter: done without busy, burst still chains.
    mode = 1;
    enq(0, 1'b0, 8'hE1); enq(0, 1'b1, 8'hE2);
    expect_byte(0, 8'hE1); expect_byte(0, 8'hE2);
    run_until_quiet(40, "t7");
    mode = 0;

    // Stray tx_done while idle is ignored.
    inject_done = 1'b1;
    step();
    step();
    chk("t8_active", 32'(active), 0);
    chk("t8_start", 32'(tx_start), 0);
    chk("t8_timeout", 32'(timeout_err), 0);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
